// File: rtl/vec_mem_pkg.sv
// Shared types and widths for the vector data-memory port.
// LANES, DATA_W and ADDR_W are the same values the cpu cores use.
package vec_mem_pkg;

    localparam int LANES  = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;

    typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // True when more than one bit of a request vector (up to 8 requesters) is set.
    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/vec_mem_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first set request bit at or after
// ptr, wrapping modulo N_REQ. Purely combinational.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;

    // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = N_REQ'(req_dbl >> ptr);
        valid   = 1'b0;
        off     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                valid = 1'b1;
                off   = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(N_REQ)) begin
            sum = sum - (IDX_W + 1)'(N_REQ);
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/vec_mem_arbiter.sv
// Round-robin arbiter sharing one vector data-memory port between N_REQ cores.
// One transaction in flight at a time; ack pulses to the owner on completion.
// Optional build macro ARB_PERF_CNT_EN adds grant_cnt / conflict_cnt outputs.
//
// state | meaning
// IDLE  | waiting for any req; picks owner and latches its fields
// ISSUE | mem_en strobe for one cycle, latency counter loaded
// WAIT  | counting RAM read latency; captures mem_rdata on reads
// DONE  | ack to owner for one cycle, rr_ptr advanced past owner
module vec_mem_arbiter
    import vec_mem_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             req_we,
    input  logic [N_REQ-1:0]             req_vs,
    input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
    input  vec_t [N_REQ-1:0]             req_wdata,
    output logic [N_REQ-1:0]             ack,
    output vec_t                         rdata,
    output logic                         busy,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic                         mem_vs,
    output logic [ADDR_W-1:0]            mem_addr,
    output vec_t                         mem_wdata,
    input  vec_t                         mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [N_REQ-1:0][15:0]       grant_cnt,
    output logic [15:0]                  conflict_cnt
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               we_q, we_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic               mem_vs_q, mem_vs_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    vec_t               mem_wdata_q, mem_wdata_d;
    vec_t               rdata_q, rdata_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and registered-output logic of the transaction FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        we_d        = we_q;
        lat_cnt_d   = lat_cnt_q;
        ack_d       = '0;
        busy_d      = busy_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_vs_d    = mem_vs_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d     = pick_idx;
                    we_d        = req_we[pick_idx];
                    mem_en_d    = 1'b1;
                    mem_we_d    = req_we[pick_idx];
                    mem_vs_d    = req_vs[pick_idx];
                    mem_addr_d  = req_addr[pick_idx];
                    mem_wdata_d = req_wdata[pick_idx];
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_W'(MEM_LAT - 1);
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end else begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    ack_d[owner_q] = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: begin
                rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and all arbiter outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            we_q        <= 1'b0;
            lat_cnt_q   <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_vs_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            lat_cnt_q   <= lat_cnt_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_vs_q    <= mem_vs_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_vs    = mem_vs_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [N_REQ-1:0][15:0] grant_cnt_q, grant_cnt_d;
    logic [15:0]            conflict_cnt_q, conflict_cnt_d;

    // Saturating per-core grant counters and multi-request pick counter.
    always_comb begin
        grant_cnt_d    = grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (ack_q[k] && grant_cnt_q[k] != 16'hFFFF) begin
                grant_cnt_d[k] = grant_cnt_q[k] + 16'd1;
            end
        end
        if (state_q == IDLE && pick_valid && multi_hot(8'(req)) &&
            conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt    = grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`else
    // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Directed bench for vec_mem_arbiter with a behavioural RAM of MEM_LAT latency.
module tb_vec_mem_arbiter;
    import vec_mem_pkg::*;

    localparam int MEM_LAT = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [3:0]             req, req_we, req_vs;
    logic [3:0][ADDR_W-1:0] req_addr;
    vec_t [3:0]             req_wdata;
    logic [3:0]             ack;
    vec_t                   rdata;
    logic                   busy, mem_en, mem_we, mem_vs;
    logic [ADDR_W-1:0]      mem_addr;
    vec_t                   mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [3:0][15:0]       grant_cnt;
    logic [15:0]            conflict_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    vec_mem_arbiter #(.N_REQ(4), .MEM_LAT(MEM_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_vs    (req_vs),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_vs    (mem_vs),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: preload word a lane l = 0x1000_0000 + a*256 + l;
    // scalar writes touch lane 15 only; read data is junk outside its slot.
    vec_t ram [0:63];
    vec_t pipe [MEM_LAT];
    logic loaded = 1'b0;
    vec_t junk;
    assign junk      = {LANES{32'hDEAD_BEEF}};
    assign mem_rdata = pipe[MEM_LAT-1];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 64; a++)
                for (int l = 0; l < LANES; l++)
                    ram[a][l] <= 32'h1000_0000 + 32'(a * 256) + 32'(l);
            loaded <= 1'b1;
        end else if (mem_en && mem_we) begin
            if (mem_vs) ram[mem_addr[5:0]] <= mem_wdata;
            else        ram[mem_addr[5:0]][15] <= mem_wdata[15];
        end
        pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[5:0]] : junk;
        for (int s = 1; s < MEM_LAT; s++) pipe[s] <= pipe[s-1];
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One uncontended transaction with exact latency checks.
    task automatic xact(input logic [1:0] c, input logic we, input logic vs,
                        input logic [ADDR_W-1:0] a, input vec_t wd);
        req_we[c] = we; req_vs[c] = vs; req_addr[c] = a; req_wdata[c] = wd;
        req[c] = 1'b1;
        tick;
        check("issue_en", mem_en, 1'b1);
        check("issue_we", mem_we, we);
        check("issue_vs", mem_vs, vs);
        check("issue_addr", mem_addr, a);
        check("issue_busy", busy, 1'b1);
        if (we) check("issue_wdata", mem_wdata, wd);
        repeat (MEM_LAT) begin
            tick;
            check("ack_early", ack, 4'b0000);
            check("en_single", mem_en, 1'b0);
        end
        tick;
        check("ack_owner", ack, 4'b0001 << c);
        req[c] = 1'b0;
        tick;
        check("ack_pulse", ack, 4'b0000);
        check("busy_clr", busy, 1'b0);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick;
            n++;
        end while (ack == 4'b0000 && n < 40);
        check("ack_seen", |ack, 1'b1);
    endtask

    vec_t exp_v, wv, prev;
    int   gap;

    initial begin
        rst = 1'b0; req = '0; req_we = '0; req_vs = '0; req_addr = '0; req_wdata = '0;
        repeat (3) tick;
        check("rst_ack", ack, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_en", mem_en, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_vs", mem_vs, 1'b0);
        check("rst_addr", mem_addr, 13'h0);
        check("rst_wdata", mem_wdata, 512'h0);
        check("rst_rdata", rdata, 512'h0);
        rst = 1'b1;
        tick;

        // 1: single vector read by core1
        xact(2'd1, 1'b0, 1'b1, 13'h010, '0);
        for (int l = 0; l < LANES; l++) exp_v[l] = 32'h1000_1000 + 32'(l);
        check("t1_rdata", rdata, exp_v);

        // 2: write then read back by core0
        for (int l = 0; l < LANES; l++) wv[l] = 32'hA0 + 32'(l);
        prev = rdata;
        xact(2'd0, 1'b1, 1'b1, 13'h005, wv);
        check("t2_rdata_hold", rdata, exp_v);
        xact(2'd0, 1'b0, 1'b1, 13'h005, '0);
        check("t2_readback", rdata, wv);

        // scalar write/read: only lane 15 reaches the RAM, all lanes forwarded
        for (int l = 0; l < LANES; l++) wv[l] = 32'hC000_0000 + 32'(l);
        xact(2'd2, 1'b1, 1'b0, 13'h006, wv);
        xact(2'd2, 1'b0, 1'b0, 13'h006, '0);
        for (int l = 0; l < LANES; l++) exp_v[l] = 32'h1000_0600 + 32'(l);
        exp_v[15] = 32'hC000_000F;
        check("scalar_rd", rdata, exp_v);

        // 3: all four held from reset release
        rst = 1'b0;
        req_we = '0; req_vs = 4'b1111;
        req_addr = {13'h003, 13'h002, 13'h001, 13'h000};
        req = 4'b1111;
        tick;
        check("t3_rst_rdata", rdata, 512'h0);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_ack(gap);
            check("t3_order", ack, 4'b0001 << (k % 4));
            if (k > 0) check("t3_gap", gap, 3 + MEM_LAT);
        end
        tick;
`ifdef ARB_PERF_CNT_EN
        check("t6_grant", grant_cnt, {4{16'd2}});
        check("t6_conflict", conflict_cnt, 16'd8);
`endif
        req = '0;
        tick;

        // 4: wrap; core2 alone moves rr_ptr to 3, then 1001 -> core3 then core0
        xact(2'd2, 1'b0, 1'b1, 13'h010, '0);
        req = 4'b1001;
        wait_ack(gap);
        check("t4_first", ack, 4'b1000);
        wait_ack(gap);
        check("t4_second", ack, 4'b0001);
        req = '0;
        tick;
        tick;

        // 5: reset during WAIT
        req_we[1] = 1'b0; req_vs[1] = 1'b1; req_addr[1] = 13'h010;
        req[1] = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        check("t5_en", mem_en, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_ack", ack, 4'b0000);
        check("t5_addr", mem_addr, 13'h0);
        check("t5_rdata", rdata, 512'h0);
        req = '0;
        repeat (4) begin
            tick;
            check("t5_no_ack", ack, 4'b0000);
        end
        rst = 1'b1;
        tick;
        xact(2'd1, 1'b0, 1'b1, 13'h010, '0);
        for (int l = 0; l < LANES; l++) exp_v[l] = 32'h1000_1000 + 32'(l);
        check("t5_after", rdata, exp_v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
